rdmx_rx_extractor: RTL

Receive-side framing stage between the Ethernet RX AXI-Stream and the PCIe write engine. Each incoming RDMX packet is split into two outputs. The first 64-byte beat is the complete Eth/IPv4/UDP/RDMX header; it is latched and decoded into a write descriptor (target address, byte count). The payload beats that follow are forwarded as a length-checked stream.

---
 rtl/rdmx_pkg.sv | 22 ++
 rtl/rdmx_rx_extractor_decoder.sv | 24 ++
 rtl/rdmx_rx_extractor.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rdmx_pkg.sv
// rtl/rdmx_pkg.sv - shared RDMX header constants and extractor state encoding
package rdmx_pkg;

  localparam int BEAT_BYTES    = 64;
  localparam int UDP_HDR_LEN   = 8;
  localparam int RDMX_HDR_LEN  = 22;

  // Byte offsets inside the 64-byte header beat (Eth 14 + IPv4 20 = 34, UDP at 34).
  localparam int UDP_LEN_OFF   = 38;
  localparam int RDMX_ADDR_OFF = 42;

  // Captured header fields: {8 address bytes, 2 udp_length bytes}, wire order.
  localparam int HDR_W = 80;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_META  = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rdmx_rx_extractor_decoder.sv
// rtl/rdmx_rx_extractor_decoder.sv - rdmx_decoder: header fields to write descriptor
module rdmx_decoder
  import rdmx_pkg::*;
(
  input  logic [HDR_W-1:0] hdr_i,
  output logic [63:0]      addr_o,
  output logic [15:0]      payload_bytes_o,
  output logic [15:0]      payload_cycles_o
);

  logic [15:0] udp_len;

  // Header fields are big-endian on the wire; hdr_i keeps wire byte order.
  always_comb begin
    udp_len = {hdr_i[7:0], hdr_i[15:8]};
    addr_o  = '0;
    for (int i = 0; i < 8; i++) begin
      addr_o[8*(7-i) +: 8] = hdr_i[16 + 8*i +: 8];
    end
    payload_bytes_o  = udp_len - 16'(UDP_HDR_LEN + RDMX_HDR_LEN);
    payload_cycles_o = {6'd0, payload_bytes_o[15:6]} + {15'd0, |payload_bytes_o[5:0]};
  end

endmodule

// File: rtl/rdmx_rx_extractor.sv
// rtl/rdmx_rx_extractor.sv - splits RDMX packets into a write descriptor and a length-checked payload stream
module rdmx_rx_extractor
  import rdmx_pkg::*;
#(
  parameter int MAX_BYTES = 8192
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] axis_in_tdata,
  input  logic [63:0]  axis_in_tkeep,
  input  logic         axis_in_tlast,
  input  logic         axis_in_tvalid,
  output logic         axis_in_tready,
  output logic [63:0]  meta_addr,
  output logic [15:0]  meta_bytes,
  output logic         meta_valid,
  input  logic         meta_ready,
  output logic [511:0] axis_out_tdata,
  output logic [63:0]  axis_out_tkeep,
  output logic         axis_out_tlast,
  output logic         axis_out_tvalid,
  input  logic         axis_out_tready,
  output logic         err_runt,
  output logic         err_len,
  output logic         err_short,
  output logic         err_long,
  output logic [31:0]  pkt_count,
  output logic [31:0]  drop_count
);

  state_e           state_q, state_d;
  logic [HDR_W-1:0] hdr_q;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      pkt_count_q, drop_count_q;
  logic             err_runt_q, err_len_q, err_short_q, err_long_q;
  logic             err_runt_d, err_len_d, err_short_d, err_long_d;
  logic             hdr_load, pkt_inc, drop_inc;

  logic [63:0]      dec_addr;
  logic [15:0]      dec_bytes, dec_cycles;
  logic             len_bad, exp_last;
  logic [63:0]      last_keep;

  rdmx_decoder u_decoder (
    .hdr_i            (hdr_q),
    .addr_o           (dec_addr),
    .payload_bytes_o  (dec_bytes),
    .payload_cycles_o (dec_cycles)
  );

  assign len_bad   = (dec_bytes == 16'd0) || (int'({16'd0, dec_bytes}) > MAX_BYTES);
  assign exp_last  = (cnt_q == 16'd1);
  assign last_keep = (dec_bytes[5:0] == 6'd0) ? '1 : ((64'd1 << dec_bytes[5:0]) - 64'd1);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    axis_in_tready  = 1'b0;
    axis_out_tvalid = 1'b0;
    axis_out_tdata  = '0;
    axis_out_tkeep  = '0;
    axis_out_tlast  = 1'b0;
    meta_valid      = 1'b0;
    hdr_load        = 1'b0;
    pkt_inc         = 1'b0;
    drop_inc        = 1'b0;
    err_runt_d      = 1'b0;
    err_len_d       = 1'b0;
    err_short_d     = 1'b0;
    err_long_d      = 1'b0;
    case (state_q)
      S_HDR: begin
        axis_in_tready = 1'b1;
        if (axis_in_tvalid) begin
          hdr_load = 1'b1;
          if (axis_in_tlast) begin
            err_runt_d = 1'b1;
            drop_inc   = 1'b1;
          end else begin
            state_d = S_META;
          end
        end
      end
      S_META: begin
        if (len_bad) begin
          err_len_d = 1'b1;
          drop_inc  = 1'b1;
          state_d   = S_DRAIN;
        end else begin
          meta_valid = 1'b1;
          if (meta_ready) begin
            pkt_inc = 1'b1;
            cnt_d   = dec_cycles;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        axis_out_tvalid = axis_in_tvalid;
        axis_in_tready  = axis_out_tready;
        axis_out_tdata  = axis_in_tdata;
        axis_out_tlast  = exp_last | axis_in_tlast;
        axis_out_tkeep  = exp_last ? last_keep : axis_in_tkeep;
        if (axis_in_tvalid && axis_out_tready) begin
          cnt_d = cnt_q - 16'd1;
          if (axis_in_tlast) begin
            err_short_d = !exp_last;
            state_d     = S_HDR;
          end else if (exp_last) begin
            err_long_d = 1'b1;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        axis_in_tready = 1'b1;
        if (axis_in_tvalid && axis_in_tlast) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_HDR;
      hdr_q        <= '0;
      cnt_q        <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      err_runt_q   <= 1'b0;
      err_len_q    <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_runt_q  <= err_runt_d;
      err_len_q   <= err_len_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      if (hdr_load) begin
        hdr_q <= {axis_in_tdata[8*RDMX_ADDR_OFF +: 64], axis_in_tdata[8*UDP_LEN_OFF +: 16]};
      end
      if (pkt_inc)  pkt_count_q  <= pkt_count_q + 32'd1;
      if (drop_inc) drop_count_q <= drop_count_q + 32'd1;
    end
  end

  // Descriptor fields read as zero whenever no descriptor is being offered.
  assign meta_addr  = meta_valid ? dec_addr  : '0;
  assign meta_bytes = meta_valid ? dec_bytes : '0;

  assign err_runt   = err_runt_q;
  assign err_len    = err_len_q;
  assign err_short  = err_short_q;
  assign err_long   = err_long_q;
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;

endmodule
